// File: rtl/multicycle_accum_n.sv
// Serial signed add/subtract of N_OPS latched operands through one adder,
// with start/busy/done handshake, exact-range overflow flag and optional clamping.
module multicycle_accum_n #(
    parameter int W        = 8,
    parameter int N_OPS    = 4,
    parameter int SATURATE = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [N_OPS-1:0]      sub_mask,
    input  logic [N_OPS*W-1:0]    ops,
    output logic                  busy,
    output logic                  done,
    output logic signed [W-1:0]   result,
    output logic                  overflow
);

    localparam int IW = $clog2(N_OPS);
    localparam int AW = W + IW + 1;

    localparam logic signed [AW-1:0] MAXV = {{(AW-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [AW-1:0] MINV = {{(AW-W+1){1'b1}}, {(W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t                 state, state_nxt;
    logic [N_OPS*W-1:0]     ops_q;
    logic [N_OPS-1:0]       mask_q;
    logic [IW-1:0]          idx;
    logic signed [AW-1:0]   acc;

    logic signed [W-1:0]    cur_op;
    logic signed [AW-1:0]   cur_ext;
    logic signed [AW-1:0]   sum_nxt;
    logic                   last;
    logic                   sum_hi;
    logic                   sum_lo;
    logic signed [W-1:0]    res_nxt;

    // State register
    always_ff @(posedge clock) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ACCUM;
            ACCUM:   if (last)  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs are pure decodes of the state
    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    // Adder/subtractor and final-sum classification
    always_comb begin
        cur_op  = ops_q[idx*W +: W];
        cur_ext = {{(AW-W){cur_op[W-1]}}, cur_op};
        sum_nxt = mask_q[idx] ? (acc - cur_ext) : (acc + cur_ext);
        last    = (idx == IW'(N_OPS-1));
        sum_hi  = (sum_nxt > MAXV);
        sum_lo  = (sum_nxt < MINV);
        if (SATURATE != 0 && sum_hi)      res_nxt = MAXV[W-1:0];
        else if (SATURATE != 0 && sum_lo) res_nxt = MINV[W-1:0];
        else                              res_nxt = sum_nxt[W-1:0];
    end

    // NOTE: operand/mask holding registers carry no reset; they are always
    // written on acceptance before being read, so resetting them buys nothing.
    always_ff @(posedge clock) begin
        if (state == IDLE && start) begin
            ops_q  <= ops;
            mask_q <= sub_mask;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            acc      <= '0;
            idx      <= '0;
            result   <= '0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc <= '0;
                        idx <= '0;
                    end
                end
                ACCUM: begin
                    acc <= sum_nxt;
                    idx <= idx + 1'b1;
                    if (last) begin
                        result   <= res_nxt;
                        overflow <= sum_hi | sum_lo;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
